// File: rtl/filter_mode_controller_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the frame-synchronous filter mode controller.
package filter_ctrl_pkg;

  // Width of the BPM estimate carried through the pipeline
  localparam int BPM_W = 8;

  // Mode encoding: bit0 enables threshold, bit1 enables brightness
  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_THRESH = 2'b01;
  localparam logic [1:0] MODE_BRIGHT = 2'b10;
  localparam logic [1:0] MODE_BOTH   = 2'b11;

  // Commit state machine states
  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT
  } state_t;

  // Mode button cycles bypass -> thresh -> bright -> both -> bypass
  function automatic logic [1:0] nextMode(input logic [1:0] currentMode);
    logic [1:0] result;
    case (currentMode)
      MODE_BYPASS: result = MODE_THRESH;
      MODE_THRESH: result = MODE_BRIGHT;
      MODE_BRIGHT: result = MODE_BOTH;
      default:     result = MODE_BYPASS;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
// Synchronises one raw active-low pushbutton, debounces it and emits a
// single-cycle press pulse on each accepted release->press transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_count;
  logic          r_press;

  // Two-flop synchroniser; idles at the released (high) level
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for the full debounce window; pulse on press
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_level <= 1'b1;
      r_count <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_count == LAST_COUNT) begin
          r_level <= r_sync2;
          r_count <= '0;
          r_press <= r_level & ~r_sync2;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/filter_mode_controller.sv
`timescale 1ns/1ps
// Frame-synchronous configuration controller: buttons edit a shadow copy of
// the mode and BPM, and the active copy is only updated at a frame boundary.
module filter_mode_controller
  import filter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BPM_MIN         = 60,
  parameter int BPM_MAX         = 200,
  parameter int BPM_STEP        = 5,
  parameter int BPM_DEFAULT     = 150
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_key_mode_n,
  input  logic             i_key_up_n,
  input  logic             i_key_dn_n,
  input  logic             i_frame_start,
  output logic [1:0]       o_mode,
  output logic             o_thresh_enable,
  output logic             o_bright_enable,
  output logic [BPM_W-1:0] o_bpm_estimate,
  output logic             o_cfg_update
);

  logic             w_modePress;
  logic             w_upPress;
  logic             w_dnPress;
  logic [BPM_W:0]   w_bpmWide;
  logic [BPM_W:0]   w_bpmUp;
  logic [BPM_W:0]   w_bpmDn;
  logic             w_differs;

  logic [1:0]       r_shadowMode;
  logic [BPM_W-1:0] r_shadowBpm;
  logic [1:0]       r_mode;
  logic [BPM_W-1:0] r_bpm;
  logic             r_cfgUpdate;
  state_t           r_state;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyMode (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_key_n   (i_key_mode_n),
    .o_press   (w_modePress)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyUp (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_key_n   (i_key_up_n),
    .o_press   (w_upPress)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_keyDn (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_key_n   (i_key_dn_n),
    .o_press   (w_dnPress)
  );

  // Saturating BPM step done one bit wider so neither direction can wrap
  always_comb begin
    w_bpmWide = {1'b0, r_shadowBpm};
    w_bpmUp   = w_bpmWide + (BPM_W+1)'(BPM_STEP);
    if (w_bpmUp > (BPM_W+1)'(BPM_MAX)) begin
      w_bpmUp = (BPM_W+1)'(BPM_MAX);
    end
    if (w_bpmWide < (BPM_W+1)'(BPM_MIN + BPM_STEP)) begin
      w_bpmDn = (BPM_W+1)'(BPM_MIN);
    end else begin
      w_bpmDn = w_bpmWide - (BPM_W+1)'(BPM_STEP);
    end
  end

  assign w_differs = (r_shadowMode != r_mode) || (r_shadowBpm != r_bpm);

  // Shadow registers follow button presses; conflicting up/down presses cancel out
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_shadowMode <= MODE_BOTH;
      r_shadowBpm  <= BPM_W'(BPM_DEFAULT);
    end else begin
      if (w_modePress) begin
        r_shadowMode <= nextMode(r_shadowMode);
      end
      if (w_upPress && !w_dnPress) begin
        r_shadowBpm <= w_bpmUp[BPM_W-1:0];
      end else if (w_dnPress && !w_upPress) begin
        r_shadowBpm <= w_bpmDn[BPM_W-1:0];
      end
    end
  end

  // Commit FSM: wait for a real difference, then copy shadow to active at the next frame start
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_mode      <= MODE_BOTH;
      r_bpm       <= BPM_W'(BPM_DEFAULT);
      r_cfgUpdate <= 1'b0;
    end else begin
      r_cfgUpdate <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_differs) begin
            r_state <= PENDING;
          end
        end
        PENDING: begin
          if (!w_differs) begin
            r_state <= IDLE;
          end else if (i_frame_start) begin
            r_state <= COMMIT;
          end
        end
        COMMIT: begin
          r_mode      <= r_shadowMode;
          r_bpm       <= r_shadowBpm;
          r_cfgUpdate <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_mode          = r_mode;
  assign o_thresh_enable = r_mode[0];
  assign o_bright_enable = r_mode[1];
  assign o_bpm_estimate  = r_bpm;
  assign o_cfg_update    = r_cfgUpdate;

endmodule

// File: tb/tb_filter_mode_controller.sv
`timescale 1ns/1ps
// Scoreboard bench for filter_mode_controller: every expected commit is queued
// when its frame_start is issued and checked when cfg_update appears.
module tb_filter_mode_controller;

  logic       clk        = 1'b0;
  logic       reset_n    = 1'b1;
  logic       keyModeN   = 1'b1;
  logic       keyUpN     = 1'b1;
  logic       keyDnN     = 1'b1;
  logic       frameStart = 1'b0;
  logic [1:0] mode;
  logic       threshEn;
  logic       brightEn;
  logic [7:0] bpm;
  logic       cfgUpdate;

  int         assertCount = 0;
  int         failCount   = 0;
  logic [9:0] expQ[$];
  logic [9:0] expEntry;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  filter_mode_controller #(
    .DEBOUNCE_CYCLES (4),
    .BPM_MIN         (60),
    .BPM_MAX         (200),
    .BPM_STEP        (5),
    .BPM_DEFAULT     (150)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_key_mode_n    (keyModeN),
    .i_key_up_n      (keyUpN),
    .i_key_dn_n      (keyDnN),
    .i_frame_start   (frameStart),
    .o_mode          (mode),
    .o_thresh_enable (threshEn),
    .o_bright_enable (brightEn),
    .o_bpm_estimate  (bpm),
    .o_cfg_update    (cfgUpdate)
  );

  task automatic checkOutput(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each cfg_update must match the oldest queued commit
  always @(negedge clk) begin
    if (reset_n && cfgUpdate) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected cfg_update", 1, 0);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("commit mode", int'(mode), int'(expEntry[9:8]));
        checkOutput("commit thresh_enable", int'(threshEn), int'(expEntry[8]));
        checkOutput("commit bright_enable", int'(brightEn), int'(expEntry[9]));
        checkOutput("commit bpm", int'(bpm), int'(expEntry[7:0]));
      end
    end
  end

  // Advance n rising edges and land 2 ns after the last one
  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setKey(input int k, input logic v);
    case (k)
      0:       keyModeN = v;
      1:       keyUpN   = v;
      default: keyDnN   = v;
    endcase
  endtask

  // One clean press: 0 = mode, 1 = up, 2 = down
  task automatic applyStimulus(input int k);
    setKey(k, 1'b0);
    waitCycles(10);
    setKey(k, 1'b1);
    waitCycles(10);
  endtask

  task automatic commitFrame(input bit expectCommit, input logic [1:0] m, input logic [7:0] b);
    if (expectCommit) expQ.push_back({m, b});
    frameStart = 1'b1;
    waitCycles(1);
    frameStart = 1'b0;
    waitCycles(6);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(2);
  endtask

  // Hard stop in case something never returns
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    #1 reset_n = 1'b0;
    #11;
    checkOutput("reset mode", int'(mode), 3);
    checkOutput("reset bpm", int'(bpm), 150);
    checkOutput("reset cfg_update", int'(cfgUpdate), 0);
    waitCycles(1);
    reset_n = 1'b1;
    waitCycles(2);

    // Idle frames must not commit anything
    repeat (3) begin
      commitFrame(1'b0, 2'b00, 8'd0);
      waitCycles(10);
    end
    checkOutput("idle mode", int'(mode), 3);
    checkOutput("idle bpm", int'(bpm), 150);

    // Glitchy mode press, then a long wait before the frame boundary
    repeat (2) begin
      setKey(0, 1'b0);
      waitCycles(1);
      setKey(0, 1'b1);
      waitCycles(1);
    end
    applyStimulus(0);
    waitCycles(40);
    checkOutput("held mode before frame", int'(mode), 3);
    checkOutput("held bpm before frame", int'(bpm), 150);
    checkOutput("no cfg_update before frame", int'(cfgUpdate), 0);
    commitFrame(1'b1, 2'b00, 8'd150);
    checkOutput("mode after commit", int'(mode), 0);
    checkOutput("thresh after commit", int'(threshEn), 0);
    checkOutput("bright after commit", int'(brightEn), 0);

    // BPM stepping and saturation
    repeat (3) applyStimulus(1);
    waitCycles(5);
    commitFrame(1'b1, 2'b00, 8'd165);
    checkOutput("bpm 165", int'(bpm), 165);
    repeat (10) applyStimulus(1);
    waitCycles(5);
    commitFrame(1'b1, 2'b00, 8'd200);
    checkOutput("bpm saturated high", int'(bpm), 200);
    repeat (40) applyStimulus(2);
    waitCycles(5);
    commitFrame(1'b1, 2'b00, 8'd60);
    checkOutput("bpm saturated low", int'(bpm), 60);

    // Up then down cancels the pending change
    doReset();
    checkOutput("post-reset mode", int'(mode), 3);
    applyStimulus(1);
    applyStimulus(2);
    waitCycles(5);
    commitFrame(1'b0, 2'b00, 8'd0);
    checkOutput("cancelled bpm", int'(bpm), 150);
    checkOutput("cancelled mode", int'(mode), 3);

    // Mode shadow update lands exactly in the COMMIT cycle of a BPM change
    applyStimulus(1);
    waitCycles(5);
    setKey(0, 1'b0);
    waitCycles(5);
    expQ.push_back({2'b11, 8'd155});
    frameStart = 1'b1;
    waitCycles(1);
    frameStart = 1'b0;
    waitCycles(8);
    setKey(0, 1'b1);
    waitCycles(10);
    checkOutput("split commit mode", int'(mode), 3);
    checkOutput("split commit bpm", int'(bpm), 155);
    commitFrame(1'b1, 2'b00, 8'd155);
    checkOutput("late mode commit", int'(mode), 0);

    // Asynchronous reset mid-cycle discards a pending change
    applyStimulus(1);
    waitCycles(3);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async reset mode", int'(mode), 3);
    checkOutput("async reset bpm", int'(bpm), 150);
    checkOutput("async reset cfg_update", int'(cfgUpdate), 0);
    waitCycles(2);
    reset_n = 1'b1;
    waitCycles(2);
    commitFrame(1'b0, 2'b00, 8'd0);
    checkOutput("after reset mode", int'(mode), 3);
    checkOutput("after reset bpm", int'(bpm), 150);

    waitCycles(5);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
